// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, RGB332 field positions and sync polarity.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;

   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;

   // 0 = active-low sync pulses; the idle level is the inverse
   localparam logic VGA_SYNC_POL = 1'b0;

   // RGB332 byte layout {R[7:5], G[4:2], B[1:0]}
   localparam int RED_MSB = 7;
   localparam int RED_LSB = 5;
   localparam int GRN_MSB = 4;
   localparam int GRN_LSB = 2;
   localparam int BLU_MSB = 1;
   localparam int BLU_LSB = 0;

   // Full period of one axis (line or frame) in counter steps
   function automatic int axis_total(input int act, input int front, input int sync, input int back);
      return act + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus active/sync/last decodes.
// Latency: count updates one clock after i_step/i_clr; decodes are combinational from count.
// Backpressure: none; i_clr has priority over i_step and parks the counter at 0.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = VGA_H_ACTIVE,
   parameter int FRONT  = VGA_H_FRONT,
   parameter int SYNC   = VGA_H_SYNC,
   parameter int BACK   = VGA_H_BACK,
   parameter int CW     = 11
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_clr,
   input  logic          i_step,
   output logic [CW-1:0] count,
   output logic          in_active,
   output logic          in_sync,
   output logic          at_last
);

   localparam int            TOTAL    = axis_total(ACTIVE, FRONT, SYNC, BACK);
   localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
   localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FRONT);
   localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FRONT + SYNC);

   // Position counter: clear wins, otherwise advance and wrap after the last position
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count <= '0;
      end else if (i_clr) begin
         count <= '0;
      end else if (i_step) begin
         count <= at_last ? '0 : count + CW'(1);
      end
   end

   assign at_last   = (count == LAST);
   assign in_active = (count < ACT_END);
   assign in_sync   = (count >= SYNC_BEG) && (count < SYNC_END);

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator and RGB332 output stage that paces pixelstream via o_pixGate.
// Latency: gate/addr-reset/frame-start combinational from counters; RGB and syncs 1 clock later.
// Backpressure: none; pixelstream must present a byte on every cycle o_pixGate is high.
module vga_timing
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FRONT  = VGA_H_FRONT,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BACK   = VGA_H_BACK,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FRONT  = VGA_V_FRONT,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BACK   = VGA_V_BACK,
   parameter logic SYNC_POL = VGA_SYNC_POL,
   parameter int   CW       = 11
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_enable,
   output logic          o_pixGate,
   output logic          o_pixAddrReset,
   input  logic [7:0]    i_pixDat,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic [2:0]    o_red,
   output logic [2:0]    o_green,
   output logic [1:0]    o_blue,
   output logic [CW-1:0] o_hcount,
   output logic [CW-1:0] o_vcount,
   output logic          o_frameStart
);

   logic r_run;
   logic cnt_clr;
   logic h_active, h_sync, h_last;
   logic v_active, v_sync;
   // frame end is already visible as the h/v wrap to 0,0; the v last-decode is not needed here
   logic v_last_unused;
   logic active;

   // Run flag simply follows the enable, one clock late
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_run <= 1'b0;
      end else begin
         r_run <= i_enable;
      end
   end

   // Counters run only while already running and still enabled: a falling enable zeroes them on
   // the very next clock, and a rising enable leaves them at 0 for the first running cycle.
   assign cnt_clr = !(r_run && i_enable);

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK),
      .CW     (CW)
   ) u_h (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (cnt_clr),
      .i_step    (1'b1),
      .count     (o_hcount),
      .in_active (h_active),
      .in_sync   (h_sync),
      .at_last   (h_last)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK),
      .CW     (CW)
   ) u_v (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (cnt_clr),
      .i_step    (h_last),
      .count     (o_vcount),
      .in_active (v_active),
      .in_sync   (v_sync),
      .at_last   (v_last_unused)
   );

   assign active       = r_run && h_active && v_active;
   assign o_pixGate    = active;
   assign o_frameStart = r_run && (o_hcount == '0) && (o_vcount == '0);
   // Rewind at the first blanking line so pixelstream has the whole vblank to refill
   assign o_pixAddrReset = !r_run || ((o_hcount == '0) && (o_vcount == CW'(V_ACTIVE)));

   // Output stage: pixel and syncs registered together so they stay aligned on the pins
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_red   <= '0;
         o_green <= '0;
         o_blue  <= '0;
         o_hsync <= ~SYNC_POL;
         o_vsync <= ~SYNC_POL;
      end else begin
         o_red   <= active ? i_pixDat[RED_MSB:RED_LSB] : 3'd0;
         o_green <= active ? i_pixDat[GRN_MSB:GRN_LSB] : 3'd0;
         o_blue  <= active ? i_pixDat[BLU_MSB:BLU_LSB] : 2'd0;
         o_hsync <= (r_run && h_sync) ? SYNC_POL : ~SYNC_POL;
         o_vsync <= (r_run && v_sync) ? SYNC_POL : ~SYNC_POL;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance for line-level checks and a tiny-timing
// instance for whole-frame checks against a position-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_vga_timing;

   localparam int S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1;
   localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 8
   localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 6
   localparam int S_FRAME = S_HT * S_VT;               // 48

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-timing instance
   logic        d_rst, d_en;
   logic [7:0]  d_dat;
   logic        d_gate, d_ar, d_hsync, d_vsync, d_fs;
   logic [2:0]  d_red, d_green;
   logic [1:0]  d_blue;
   logic [10:0] d_hcount, d_vcount;

   // tiny-timing instance
   logic        s_rst, s_en;
   logic [7:0]  s_dat;
   logic        s_gate, s_ar, s_hsync, s_vsync, s_fs;
   logic [2:0]  s_red, s_green;
   logic [1:0]  s_blue;
   logic [3:0]  s_hcount, s_vcount;

   vga_timing dut_d (
      .i_clk(clk), .i_reset(d_rst), .i_enable(d_en),
      .o_pixGate(d_gate), .o_pixAddrReset(d_ar), .i_pixDat(d_dat),
      .o_hsync(d_hsync), .o_vsync(d_vsync),
      .o_red(d_red), .o_green(d_green), .o_blue(d_blue),
      .o_hcount(d_hcount), .o_vcount(d_vcount), .o_frameStart(d_fs)
   );

   vga_timing #(
      .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
      .SYNC_POL(1'b0), .CW(4)
   ) dut_s (
      .i_clk(clk), .i_reset(s_rst), .i_enable(s_en),
      .o_pixGate(s_gate), .o_pixAddrReset(s_ar), .i_pixDat(s_dat),
      .o_hsync(s_hsync), .o_vsync(s_vsync),
      .o_red(s_red), .o_green(s_green), .o_blue(s_blue),
      .o_hcount(s_hcount), .o_vcount(s_vcount), .o_frameStart(s_fs)
   );

   // reference model of the tiny instance: running flag, cycles since the run began,
   // and the values the output registers will show
   bit         m_run = 1'b0;
   int         m_pos = 0;
   logic [7:0] m_rgb = 8'h00;
   logic       m_hs = 1'b1;
   logic       m_vs = 1'b1;

   // frame-level tallies for the tiny instance
   bit phase_a = 1'b0;
   int n_gate = 0, n_ar = 0, n_fs = 0, last_fs = -1;
   int prev_h = 0, prev_v = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // expected pin fields of an RGB332 byte, by plain arithmetic
   task automatic check_rgb_d(input string tag, input int d);
      check({tag, "_r"}, 32'(d_red),   (d / 32) % 8);
      check({tag, "_g"}, 32'(d_green), (d / 4) % 8);
      check({tag, "_b"}, 32'(d_blue),  d % 4);
   endtask

   task automatic wait_d(input int h, input int v, input int budget, input string tag);
      int n = 0;
      while (!(int'(d_hcount) == h && int'(d_vcount) == v) && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(int'(d_hcount) == h && int'(d_vcount) == v), 32'd1);
   endtask

   // one clock of the tiny instance: compare against the model, drive, advance the model
   task automatic s_cycle(input bit en, input logic [7:0] dat);
      int h, v;
      bit act;
      h   = m_pos % S_HT;
      v   = (m_pos / S_HT) % S_VT;
      act = m_run && h < S_HA && v < S_VA;
      check("s_hcount", 32'(s_hcount), h);
      check("s_vcount", 32'(s_vcount), v);
      check("s_gate", 32'(s_gate), 32'(act));
      check("s_addr_rst", 32'(s_ar), 32'(!m_run || (h == 0 && v == S_VA)));
      check("s_frame_start", 32'(s_fs), 32'(m_run && h == 0 && v == 0));
      check("s_hsync", 32'(s_hsync), 32'(m_hs));
      check("s_vsync", 32'(s_vsync), 32'(m_vs));
      check("s_rgb", 32'({s_red, s_green, s_blue}), 32'(m_rgb));
      if (phase_a) begin
         if (s_gate) n_gate++;
         if (m_run && s_ar) n_ar++;
         if (s_fs) begin
            if (last_fs >= 0) check("s_fs_period", cyc - last_fs, S_FRAME);
            last_fs = cyc;
            n_fs++;
         end
         if (prev_h == S_HT - 1 && prev_v == S_VT - 1) begin
            check("s_wrap_h", 32'(s_hcount), 32'd0);
            check("s_wrap_v", 32'(s_vcount), 32'd0);
         end
         prev_h = int'(s_hcount);
         prev_v = int'(s_vcount);
      end
      s_en  = en;
      s_dat = dat;
      m_rgb = act ? dat : 8'h00;
      m_hs  = (m_run && h >= S_HA + S_HF && h < S_HA + S_HF + S_HS) ? 1'b0 : 1'b1;
      m_vs  = (m_run && v >= S_VA + S_VF && v < S_VA + S_VF + S_VS) ? 1'b0 : 1'b1;
      m_pos = (m_run && en) ? m_pos + 1 : 0;
      m_run = en;
      tick();
   endtask

   task automatic check_idle_d(input string tag);
      check({tag, "_hcount"}, 32'(d_hcount), 32'd0);
      check({tag, "_vcount"}, 32'(d_vcount), 32'd0);
      check({tag, "_hsync"}, 32'(d_hsync), 32'd1);
      check({tag, "_vsync"}, 32'(d_vsync), 32'd1);
      check({tag, "_gate"}, 32'(d_gate), 32'd0);
      check({tag, "_addr_rst"}, 32'(d_ar), 32'd1);
      check({tag, "_frame_start"}, 32'(d_fs), 32'd0);
      check_rgb_d({tag, "_rgb"}, 0);
   endtask

   initial begin
      int n;
      int fall_cyc;
      logic [7:0] d;

      d_rst = 1'b0; d_en = 1'b0; d_dat = 8'h00;
      s_rst = 1'b0; s_en = 1'b0; s_dat = 8'h00;
      #2;
      d_rst = 1'b1;
      s_rst = 1'b1;
      #2;
      // asynchronous reset takes effect before any clock edge
      check_idle_d("rst");
      tick();
      tick();
      d_rst = 1'b0;
      s_rst = 1'b0;
      tick();
      tick();
      check_idle_d("idle");

      // tiny instance: one idle cycle then exactly three frames, random pixel data
      phase_a = 1'b1;
      for (int i = 0; i < 1 + 3 * S_FRAME; i++) s_cycle(1'b1, 8'($urandom));
      phase_a = 1'b0;
      check("s_gate_total", n_gate, 3 * S_HA * S_VA);
      check("s_addr_rst_pulses", n_ar, 3);
      check("s_frame_starts", n_fs, 3);

      // tiny instance: random enable drop-outs
      for (int i = 0; i < 400; i++) s_cycle($urandom_range(0, 15) != 0, 8'($urandom));
      s_en = 1'b0;

      // default instance: first running cycle
      d_en = 1'b1;
      tick();
      check("d_start_fs", 32'(d_fs), 32'd1);
      check("d_start_h", 32'(d_hcount), 32'd0);

      // hsync pulse position, width and line period
      wait_d(656, 0, 1000, "d_wait_h656");
      check("d_hsync_at_656", 32'(d_hsync), 32'd1);
      tick();
      check("d_hsync_after_656", 32'(d_hsync), 32'd0);
      fall_cyc = cyc;
      n = 0;
      while (d_hsync == 1'b0 && n < 200) begin
         n++;
         tick();
      end
      check("d_hsync_width", n, 96);
      n = 0;
      while (d_hsync == 1'b1 && n < 1000) begin
         n++;
         tick();
      end
      check("d_line_period", cyc - fall_cyc, 800);

      // pixel path: fixed pattern then random bytes in active video
      wait_d(10, 2, 1000, "d_wait_active");
      d_dat = 8'hE3;
      tick();
      check("d_e3_r", 32'(d_red), 32'd7);
      check("d_e3_g", 32'(d_green), 32'd0);
      check("d_e3_b", 32'(d_blue), 32'd3);
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         d_dat = d;
         tick();
         check_rgb_d("d_rand_pix", int'(d));
      end
      wait_d(700, 2, 1000, "d_wait_h700");
      check("d_gate_h700", 32'(d_gate), 32'd0);
      d_dat = 8'hFF;
      tick();
      check_rgb_d("d_blank_ff", 0);

      // enable dropped mid-frame, raised 5 clocks later
      wait_d(100, 10, 9000, "d_wait_h100_v10");
      check("d_gate_before_drop", 32'(d_gate), 32'd1);
      d_en = 1'b0;
      tick();
      check("d_drop_h", 32'(d_hcount), 32'd0);
      check("d_drop_v", 32'(d_vcount), 32'd0);
      check("d_drop_gate", 32'(d_gate), 32'd0);
      check("d_drop_ar", 32'(d_ar), 32'd1);
      check_rgb_d("d_drop_lastpix", 8'hFF);
      tick();
      check_rgb_d("d_drop_rgb", 0);
      check("d_drop_hsync", 32'(d_hsync), 32'd1);
      check("d_drop_vsync", 32'(d_vsync), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("d_low_gate", 32'(d_gate), 32'd0);
         check("d_low_ar", 32'(d_ar), 32'd1);
      end
      d_en = 1'b1;
      tick();
      check("d_rise_h", 32'(d_hcount), 32'd0);
      check("d_rise_v", 32'(d_vcount), 32'd0);
      check("d_rise_fs", 32'(d_fs), 32'd1);
      check("d_rise_ar", 32'(d_ar), 32'd0);

      // enable dropped then asynchronous reset in the middle of a clock period
      wait_d(299, 0, 1000, "d_wait_h299");
      d_dat = 8'hFF;
      tick();
      check("d_pre_rst_h", 32'(d_hcount), 32'd300);
      check_rgb_d("d_pre_rst_pix", 8'hFF);
      d_en = 1'b0;
      #2;
      d_rst = 1'b1;
      #1;
      check_idle_d("d_async_rst");
      tick();
      tick();
      d_rst = 1'b0;
      tick();
      check("d_post_rst_h", 32'(d_hcount), 32'd0);
      check("d_post_rst_ar", 32'(d_ar), 32'd1);
      d_en = 1'b1;
      tick();
      check("d_restart_h", 32'(d_hcount), 32'd0);
      check("d_restart_v", 32'(d_vcount), 32'd0);
      check("d_restart_fs", 32'(d_fs), 32'd1);
      tick();
      check("d_restart_h1", 32'(d_hcount), 32'd1);
      check("d_restart_fs1", 32'(d_fs), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
